// File: rtl/spi_pkg.sv
// spi_pkg -- shared types for the configurable SPI master.
//   state_t    : transfer sequencer states
//   spi_mode_t : per-transfer wire format latched on start
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD,
    DONE
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen -- SCK timing for spi_master_cfg.
// Produces a tick at the end of every half-period of H = div+1 clk cycles
// while a transfer phase is active, and qualifies the ticks that move SCK
// into leading / trailing edges.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   active          high in SETUP, TRANSFER and HOLD
//   in_setup        high in SETUP
//   in_transfer     high in TRANSFER
//   div             latched divider value (half-period = div+1 cycles)
//   len             latched transfer length in bits (1..MAX)
//   tick            last cycle of the current half-period
//   lead_stb        SCK moves to its active level at the next clk edge
//   trail_stb       SCK returns to its idle level at the next clk edge
//   xfer_end        last cycle of TRANSFER
module spi_sck_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int LEN_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic                 in_setup,
  input  logic                 in_transfer,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [LEN_W-1:0]     len,
  output logic                 tick,
  output logic                 lead_stb,
  output logic                 trail_stb,
  output logic                 xfer_end
);

  localparam int CNT_W = LEN_W + 1;

  logic [DIV_WIDTH-1:0] div_cnt;
  logic [CNT_W-1:0]     half_cnt;
  logic [CNT_W-1:0]     last_half;

  assign tick      = active && (div_cnt == div);
  assign last_half = {len, 1'b0} - CNT_W'(1);
  assign xfer_end  = in_transfer && tick && (half_cnt == last_half);

  // The SETUP tick is edge 1 (leading). A TRANSFER tick closing half-period h
  // is edge h+2, so odd h is leading and even h trailing; the final
  // half-period ends the transfer with SCK already idle, so it is no edge.
  assign lead_stb  = tick && (in_setup || (in_transfer && half_cnt[0] && !xfer_end));
  assign trail_stb = tick && in_transfer && !half_cnt[0];

  // Divider counter compares before incrementing and clears on the tick, so
  // div at its maximum never wraps the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!active || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // Half-period counter, only meaningful inside TRANSFER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
    end else if (!in_transfer) begin
      half_cnt <= '0;
    end else if (tick) begin
      half_cnt <= half_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg -- runtime-configurable SPI master (mode, bit order,
// length, divider, chip select), one transfer per start pulse.
// Optional feature macro: SPI_LOOPBACK_EN adds input 'loopback'; when
// latched high the received bit is taken from the internal MOSI.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             transfer request, accepted only in IDLE
//   tx_data           right-justified transmit word
//   xfer_len          bits per transfer (0 or >MAX means MAX)
//   cs_sel            chip-select index (out of range selects none)
//   cpol, cpha        SPI mode
//   lsb_first         bit order on the wire
//   clk_div           SCK half-period = clk_div+1 clk cycles
//   busy, done        handshake; done pulses for one cycle with rx_data
//   rx_data           right-justified received word
//   spi_sck, spi_cs_n, spi_mosi, spi_miso   SPI pins
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int MAX_DATA_LENGTH = 32,
  parameter int NUM_CS          = 4,
  parameter int DIV_WIDTH       = 8,
  localparam int LEN_W = $clog2(MAX_DATA_LENGTH + 1),
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [MAX_DATA_LENGTH-1:0] tx_data,
  input  logic [LEN_W-1:0]           xfer_len,
  input  logic [CS_W-1:0]            cs_sel,
  input  logic                       cpol,
  input  logic                       cpha,
  input  logic                       lsb_first,
  input  logic [DIV_WIDTH-1:0]       clk_div,
  output logic                       busy,
  output logic                       done,
  output logic [MAX_DATA_LENGTH-1:0] rx_data,
  output logic                       spi_sck,
  output logic [NUM_CS-1:0]          spi_cs_n,
  output logic                       spi_mosi,
  input  logic                       spi_miso
`ifdef SPI_LOOPBACK_EN
  ,
  input  logic                       loopback
`endif
);

  localparam int IDX_W = (MAX_DATA_LENGTH > 1) ? $clog2(MAX_DATA_LENGTH) : 1;

  state_t                     state, state_next;
  spi_mode_t                  mode_q;
  logic [MAX_DATA_LENGTH-1:0] tx_sh, rx_sh;
  logic [LEN_W-1:0]           len_q, len_eff, samp_cnt;
  logic [CS_W-1:0]            cs_q;
  logic [DIV_WIDTH-1:0]       div_q;
  logic                       sck_q;
  logic                       in_setup, in_transfer, active;
  logic                       tick, lead_stb, trail_stb, xfer_end;
  logic                       start_ok, sample_stb, shift_stb, tx_bit, rx_bit;

  assign start_ok = (state == IDLE) && start;
  assign len_eff  = ((xfer_len == '0) || (xfer_len > LEN_W'(MAX_DATA_LENGTH)))
                    ? LEN_W'(MAX_DATA_LENGTH) : xfer_len;

  spi_sck_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .LEN_W     (LEN_W)
  ) u_sck_gen (
    .clk         (clk),
    .rst         (rst),
    .active      (active),
    .in_setup    (in_setup),
    .in_transfer (in_transfer),
    .div         (div_q),
    .len         (len_q),
    .tick        (tick),
    .lead_stb    (lead_stb),
    .trail_stb   (trail_stb),
    .xfer_end    (xfer_end)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sequencer: each phase ends on a divider tick except TRANSFER, which ends
  // after its last half-period, and DONE, which lasts exactly one cycle.
  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    done        = 1'b0;
    in_setup    = 1'b0;
    in_transfer = 1'b0;
    active      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SETUP;
      end
      SETUP: begin
        busy     = 1'b1;
        in_setup = 1'b1;
        active   = 1'b1;
        if (tick) state_next = TRANSFER;
      end
      TRANSFER: begin
        busy        = 1'b1;
        in_transfer = 1'b1;
        active      = 1'b1;
        if (xfer_end) state_next = HOLD;
      end
      HOLD: begin
        busy   = 1'b1;
        active = 1'b1;
        if (tick) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The wire bit always sits at one end of the shift register: MSB-first
  // words are pre-aligned to the top so only len bits ever reach the wire.
  assign tx_bit   = mode_q.lsb_first ? tx_sh[0] : tx_sh[MAX_DATA_LENGTH-1];
  assign spi_mosi = busy & tx_bit;

`ifdef SPI_LOOPBACK_EN
  logic lb_q;

  // Loopback select is latched with the rest of the transfer setup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_q <= 1'b0;
    end else if (start_ok) begin
      lb_q <= loopback;
    end
  end

  assign rx_bit = lb_q ? tx_bit : spi_miso;
`else
  assign rx_bit = spi_miso;
`endif

  // CPHA=1 already presents bit 0 in SETUP, so its first leading edge does
  // not advance; the sample count stops the shift once the last bit is out
  // so MOSI holds it through the final trailing edge and HOLD.
  assign sample_stb = mode_q.cpha ? trail_stb : lead_stb;
  assign shift_stb  = (mode_q.cpha ? (lead_stb && !in_setup) : trail_stb)
                      && (samp_cnt != len_q);

  // Transfer setup is captured on the accepted start; afterwards only the
  // strobes from the SCK generator move the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      len_q    <= '0;
      samp_cnt <= '0;
      cs_q     <= '0;
      div_q    <= '0;
      sck_q    <= 1'b0;
    end else if (start_ok) begin
      mode_q   <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
      tx_sh    <= lsb_first ? tx_data
                            : (tx_data << (LEN_W'(MAX_DATA_LENGTH) - len_eff));
      rx_sh    <= '0;
      len_q    <= len_eff;
      samp_cnt <= '0;
      cs_q     <= cs_sel;
      div_q    <= clk_div;
      sck_q    <= cpol;
    end else begin
      if (lead_stb || trail_stb) begin
        sck_q <= ~sck_q;
      end
      if (shift_stb) begin
        tx_sh <= mode_q.lsb_first ? (tx_sh >> 1) : (tx_sh << 1);
      end
      if (sample_stb) begin
        samp_cnt <= samp_cnt + LEN_W'(1);
        if (mode_q.lsb_first) begin
          rx_sh[samp_cnt[IDX_W-1:0]] <= rx_bit;
        end else begin
          rx_sh <= (rx_sh << 1) | MAX_DATA_LENGTH'(rx_bit);
        end
      end
    end
  end

  // Received word becomes visible on entry to DONE and holds until the next
  // completed transfer or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= '0;
    end else if ((state == HOLD) && tick) begin
      rx_data <= rx_sh;
    end
  end

  // Idle SCK follows the live cpol input; reset forces it low regardless.
  assign spi_sck = rst ? 1'b0 : ((state == IDLE) ? cpol : sck_q);

  // One-hot active-low select while busy; an index with no matching output
  // leaves every line high.
  always_comb begin
    spi_cs_n = '1;
    if (busy) begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (int'(cs_q) == i) spi_cs_n[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg -- directed self-checking bench for spi_master_cfg.
// A behavioural SPI slave shifts out a chosen word in the transfer's mode
// and bit order and records MOSI in wire order (first bit ends up highest).
module tb_spi_master_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] tx_data;
  logic [5:0]  xfer_len;
  logic [1:0]  cs_sel;
  logic        cpol, cpha, lsb_first;
  logic [7:0]  clk_div;
  logic        busy, done;
  logic [31:0] rx_data;
  logic        spi_sck;
  logic [3:0]  spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;

  int errors = 0;
  int checks = 0;

  // Slave model configuration (written by the stimulus) and state (written
  // only by the slave process).
  logic [31:0] sl_word = '0;
  int          sl_len  = 8;
  logic        sl_lsb  = 1'b0;
  logic        sl_cpol = 1'b0;
  logic        sl_cpha = 1'b0;
  logic        sl_go   = 1'b0;
  logic        sl_go_q = 1'b0;
  logic        sl_sck_q = 1'b0;
  int          sl_idx  = 0;
  logic [31:0] cap     = '0;
  int          cap_n   = 0;

  spi_master_cfg #(
    .MAX_DATA_LENGTH (32),
    .NUM_CS          (4),
    .DIV_WIDTH       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tx_data   (tx_data),
    .xfer_len  (xfer_len),
    .cs_sel    (cs_sel),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .clk_div   (clk_div),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
`ifdef SPI_LOOPBACK_EN
    ,
    .loopback  (1'b0)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic miso_bit(logic [31:0] w, int n, logic lsb, int i);
    int j;
    if (i < 0 || i >= n) return 1'b0;
    j = lsb ? i : (n - 1 - i);
    return w[j[4:0]];
  endfunction

  assign spi_miso = miso_bit(sl_word, sl_len, sl_lsb, sl_idx);

  // Slave: CPHA=0 presents bit 0 up front and advances on trailing edges,
  // capturing MOSI on leading edges; CPHA=1 advances on leading edges and
  // captures on trailing edges.
  always @(spi_sck or sl_go) begin
    if (sl_go && !sl_go_q) begin
      sl_idx = sl_cpha ? -1 : 0;
      cap    = '0;
      cap_n  = 0;
    end else if (sl_go && (spi_sck !== sl_sck_q)) begin
      if (spi_sck !== sl_cpol) begin
        if (!sl_cpha) begin
          cap = {cap[30:0], spi_mosi};
          cap_n++;
        end else begin
          sl_idx++;
        end
      end else begin
        if (!sl_cpha) begin
          sl_idx++;
        end else begin
          cap = {cap[30:0], spi_mosi};
          cap_n++;
        end
      end
    end
    sl_go_q  = sl_go;
    sl_sck_q = spi_sck;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one transfer request at the current time (1 ns after an edge);
  // returns 1 ns into the first cycle after the start edge.
  task automatic applyStimulus(input logic [31:0] tx, input logic [5:0] len,
                               input logic [1:0] cs, input logic pol, input logic pha,
                               input logic lsb, input logic [7:0] div,
                               input logic [31:0] sw, input int slen);
    tx_data   = tx;
    xfer_len  = len;
    cs_sel    = cs;
    cpol      = pol;
    cpha      = pha;
    lsb_first = lsb;
    clk_div   = div;
    sl_word   = sw;
    sl_len    = slen;
    sl_lsb    = lsb;
    sl_cpol   = pol;
    sl_cpha   = pha;
    start     = 1'b1;
    #1 sl_go  = 1'b1;
    @(posedge clk);
    #1 start  = 1'b0;
  endtask

  // Waits for done with a cycle budget; cyc is the cycle index counted from
  // the start cycle (index 0).
  task automatic waitDone(input int cyc0, output int cyc);
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    sl_go = 1'b0;
    checkOutput("done_seen", {31'd0, done}, 32'd1);
  endtask

  // Watchdog so a stuck simulation still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int dcnt;
    int bcnt;

    // Reset values, with cpol high to show reset forces SCK low.
    rst = 1'b1; start = 1'b0; tx_data = '0; xfer_len = 6'd8; cs_sel = '0;
    cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; clk_div = '0;
    #12;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_rx", rx_data, 32'd0);
    checkOutput("rst_cs", {28'd0, spi_cs_n}, 32'hF);
    checkOutput("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    checkOutput("rst_sck", {31'd0, spi_sck}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_sck_cpol", {31'd0, spi_sck}, 32'd1);
    @(posedge clk); #1;

    // 1: mode 0, 8 bits, H=1.
    applyStimulus(32'hA5, 6'd8, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h3C, 8);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    checkOutput("t1_cs", {28'd0, spi_cs_n}, 32'hE);
    checkOutput("t1_first_mosi", {31'd0, spi_mosi}, 32'd1);
    checkOutput("t1_setup_sck", {31'd0, spi_sck}, 32'd0);
    waitDone(1, cyc);
    checkOutput("t1_latency", cyc, 32'd19);
    checkOutput("t1_rx", rx_data, 32'h3C);
    checkOutput("t1_mosi_bits", cap, 32'hA5);
    checkOutput("t1_edges", cap_n, 32'd8);
    checkOutput("t1_done_cs", {28'd0, spi_cs_n}, 32'hF);
    checkOutput("t1_done_mosi", {31'd0, spi_mosi}, 32'd0);
    @(posedge clk); #1;
    checkOutput("t1_after_done", {31'd0, done}, 32'd0);
    checkOutput("t1_rx_hold", rx_data, 32'h3C);

    // 2: mode 3, 16 bits, H=4; inputs scrambled mid-transfer.
    applyStimulus(32'h1234, 6'd16, 2'd0, 1'b1, 1'b1, 1'b0, 8'd3, 32'h1234, 16);
    checkOutput("t2_setup_sck", {31'd0, spi_sck}, 32'd1);
    tx_data = '0; clk_div = '0; cpol = 1'b0; cpha = 1'b0; xfer_len = 6'd1;
    lsb_first = 1'b1; cs_sel = 2'd2;
    @(posedge clk); #1;
    checkOutput("t2_cs_latched", {28'd0, spi_cs_n}, 32'hE);
    waitDone(2, cyc);
    checkOutput("t2_latency", cyc, 32'd137);
    checkOutput("t2_rx", rx_data, 32'h1234);
    checkOutput("t2_mosi_bits", cap, 32'h1234);
    checkOutput("t2_done_sck", {31'd0, spi_sck}, 32'd1);
    @(posedge clk); #1;

    // 3: mode 1, LSB first, 5 bits, H=2.
    applyStimulus(32'h13, 6'd5, 2'd0, 1'b0, 1'b1, 1'b1, 8'd1, 32'h16, 5);
    waitDone(1, cyc);
    checkOutput("t3_latency", cyc, 32'd25);
    checkOutput("t3_rx", rx_data, 32'h16);
    checkOutput("t3_mosi_bits", cap, 32'h19);
    @(posedge clk); #1;

    // 4: start pulses mid-transfer and in the DONE cycle are ignored.
    applyStimulus(32'h9, 6'd4, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 32'h6, 4);
    checkOutput("t4_cs", {28'd0, spi_cs_n}, 32'hD);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; tx_data = 32'hF; xfer_len = 6'd2;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("t4_busy_mid", {31'd0, busy}, 32'd1);
    waitDone(5, cyc);
    checkOutput("t4_latency", cyc, 32'd11);
    checkOutput("t4_rx", rx_data, 32'h6);
    checkOutput("t4_mosi_bits", cap, 32'h9);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("t4_start_in_done", {31'd0, busy}, 32'd0);
    dcnt = 0; bcnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcnt++;
      if (busy === 1'b1) bcnt++;
    end
    checkOutput("t4_extra_done", dcnt, 32'd0);
    checkOutput("t4_extra_busy", bcnt, 32'd0);

    // 5: reset in the middle of TRANSFER, mode 2.
    applyStimulus(32'h55, 6'd8, 2'd2, 1'b1, 1'b0, 1'b0, 8'd2, 32'hFF, 8);
    repeat (8) begin @(posedge clk); #1; end
    sl_go = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("t5_cs", {28'd0, spi_cs_n}, 32'hF);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_sck", {31'd0, spi_sck}, 32'd0);
    checkOutput("t5_rx", rx_data, 32'd0);
    checkOutput("t5_mosi", {31'd0, spi_mosi}, 32'd0);
    #2 rst = 1'b0;
    #1;
    checkOutput("t5_idle_sck_hi", {31'd0, spi_sck}, 32'd1);
    cpol = 1'b0;
    #1;
    checkOutput("t5_idle_sck_lo", {31'd0, spi_sck}, 32'd0);
    @(posedge clk); #1;
    applyStimulus(32'hC3, 6'd8, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h5A, 8);
    waitDone(1, cyc);
    checkOutput("t5_latency", cyc, 32'd19);
    checkOutput("t5_rx_after", rx_data, 32'h5A);
    checkOutput("t5_mosi_bits", cap, 32'hC3);
    @(posedge clk); #1;

    // 6: cs index 3, then back-to-back len=0 (full 32 bits).
    applyStimulus(32'hA, 6'd4, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 32'h5, 4);
    checkOutput("t6_cs3", {28'd0, spi_cs_n}, 32'h7);
    waitDone(1, cyc);
    checkOutput("t6_latency", cyc, 32'd11);
    checkOutput("t6_rx", rx_data, 32'h5);
    @(posedge clk); #1;
    applyStimulus(32'hDEADBEEF, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h8BADF00D, 32);
    checkOutput("t6_b2b_busy", {31'd0, busy}, 32'd1);
    waitDone(1, cyc);
    checkOutput("t6_len0_latency", cyc, 32'd67);
    checkOutput("t6_len0_rx", rx_data, 32'h8BADF00D);
    checkOutput("t6_len0_mosi", cap, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Length above MAX clamps to MAX, LSB first.
    applyStimulus(32'h0F0F1234, 6'd40, 2'd0, 1'b0, 1'b1, 1'b1, 8'd0, 32'h13579BDF, 32);
    waitDone(1, cyc);
    checkOutput("len40_latency", cyc, 32'd67);
    checkOutput("len40_rx", rx_data, 32'h13579BDF);
    @(posedge clk); #1;

    // Maximum divider: H=256, one bit.
    applyStimulus(32'h1, 6'd1, 2'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 32'h1, 1);
    waitDone(1, cyc);
    checkOutput("divmax_latency", cyc, 32'd1025);
    checkOutput("divmax_rx", rx_data, 32'h1);
    checkOutput("divmax_mosi", cap, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
